// File: rtl/spi_btn_master.sv
// SPI mode-0 master: latches a TX word on start, shifts it out on MOSI while sampling MISO.
// Define SPI_BTN_MASTER_POLL_EN to add a free-running auto-poll that starts transfers periodically.
module spi_btn_master #(
  parameter int C_bits        = 8,
  parameter int C_clk_div     = 4,
  parameter int C_csn_setup   = 2,
  parameter int C_poll_period = 1000000
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_start,
  input  logic [C_bits-1:0] i_tx_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [C_bits-1:0] o_data,
  output logic              o_csn,
  output logic              o_sclk,
  output logic              o_mosi,
  input  logic              i_miso
);

  if (C_bits < 1 || C_clk_div < 1 || C_csn_setup < 1 || C_poll_period < 1) begin : g_bad_param
    $error("spi_btn_master: all parameters must be >= 1");
  end

  localparam int CNT_MAX = (C_clk_div > C_csn_setup) ? C_clk_div : C_csn_setup;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(C_bits + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(C_clk_div - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(C_csn_setup - 1);
  // HOLD runs one cycle longer than SETUP: its last edge is the one that raises CSn and o_done.
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(C_csn_setup);
  localparam logic [BIT_W-1:0] BITS_LAST  = BIT_W'(C_bits - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [C_bits-1:0] tx_shift;
  logic [C_bits-1:0] rx_shift;
  logic              start_req;
  logic              accept;

  assign accept = (state == ST_IDLE) && start_req;

`ifdef SPI_BTN_MASTER_POLL_EN
  localparam int POLL_W = $clog2(C_poll_period + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(C_poll_period - 1);

  logic [POLL_W-1:0] poll_cnt;
  logic              poll_tc;
  logic              poll_pend;

  assign poll_tc   = (poll_cnt == POLL_LAST);
  assign start_req = i_start | poll_tc | poll_pend;

  // A terminal count that lands while busy is remembered (once) until IDLE accepts it.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      poll_cnt  <= '0;
      poll_pend <= 1'b0;
    end else begin
      poll_cnt <= poll_tc ? '0 : poll_cnt + 1'b1;
      if (accept)
        poll_pend <= 1'b0;
      else if (poll_tc)
        poll_pend <= 1'b1;
    end
  end
`else
  assign start_req = i_start;
`endif

  // NOTE: every register below is assigned with <= so all reads in this block see
  // pre-edge values; mixing in blocking assignments would make results order-dependent.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      o_csn    <= 1'b1;
      o_sclk   <= 1'b0;
      o_mosi   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_data   <= '0;
    end else begin
      // NOTE: default deassert first; the HOLD branch overrides it for exactly one cycle.
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_csn  <= 1'b1;
          o_sclk <= 1'b0;
          if (accept) begin
            tx_shift <= i_tx_data << 1;
            o_mosi   <= i_tx_data[C_bits-1];
            o_csn    <= 1'b0;
            o_busy   <= 1'b1;
            cnt      <= '0;
            bit_cnt  <= '0;
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            state <= ST_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_LOW: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            o_sclk   <= 1'b1;
            rx_shift <= (rx_shift << 1) | C_bits'(i_miso);
            state    <= ST_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_HIGH: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            o_sclk  <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BITS_LAST) begin
              state <= ST_HOLD;
            end else begin
              o_mosi   <= tx_shift[C_bits-1];
              tx_shift <= tx_shift << 1;
              state    <= ST_LOW;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt    <= '0;
            o_csn  <= 1'b1;
            o_data <= rx_shift;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            o_mosi <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_btn_master.sv
// Directed self-checking bench for spi_btn_master with a MISO slave model that
// shifts a queued word MSB-first, updating on CSn fall and SCLK falls.
module tb_spi_btn_master;

  localparam int BITS  = 8;
  localparam int DIV   = 4;
  localparam int SETUP = 2;
  localparam int POLL  = 200;
  localparam int LAT   = 69;

  logic            clk = 1'b0;
  logic            resetn;
  logic            start;
  logic [BITS-1:0] tx_data;
  logic            busy;
  logic            done;
  logic [BITS-1:0] data;
  logic            csn;
  logic            sclk;
  logic            mosi;
  logic            miso = 1'b0;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  spi_btn_master #(
    .C_bits       (BITS),
    .C_clk_div    (DIV),
    .C_csn_setup  (SETUP),
    .C_poll_period(POLL)
  ) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_start  (start),
    .i_tx_data(tx_data),
    .o_busy   (busy),
    .o_done   (done),
    .o_data   (data),
    .o_csn    (csn),
    .o_sclk   (sclk),
    .o_mosi   (mosi),
    .i_miso   (miso)
  );

  logic [BITS-1:0] slv_q[$];
  logic [BITS-1:0] slv_sh = '0;

  always @(negedge csn) begin : slave_load
    logic [BITS-1:0] w;
    w = (slv_q.size() > 0) ? slv_q.pop_front() : '0;
    miso   <= w[BITS-1];
    slv_sh <= w << 1;
  end

  always @(negedge sclk) begin
    if (!csn) begin
      miso   <= slv_sh[BITS-1];
      slv_sh <= slv_sh << 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (done) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    resetn  = 1'b0;
    start   = 1'b0;
    tx_data = '0;
    repeat (3) tick();
    checks++; if (csn !== 1'b1) $display("FAIL reset_csn: got %b want 1", csn); else passed++;
    checks++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk); else passed++;
    checks++; if (mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else passed++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic do_transfer(input logic [BITS-1:0] tx, input logic [BITS-1:0] rx, input string name);
    int              rises = 0;
    int              lat   = -1;
    logic [BITS-1:0] mosi_w = '0;
    logic            prev;
    slv_q.push_back(rx);
    tx_data = tx;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tx_data = ~tx;
    checks++; if (busy !== 1'b1 || csn !== 1'b0)
      $display("FAIL %s_accept: busy=%b csn=%b want busy=1 csn=0", name, busy, csn); else passed++;
    prev = sclk;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (sclk && !prev) begin
        rises++;
        mosi_w = {mosi_w[BITS-2:0], mosi};
      end
      prev = sclk;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat != LAT) $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT); else passed++;
    checks++; if (rises != BITS) $display("FAIL %s_rises: got %0d want %0d", name, rises, BITS); else passed++;
    checks++; if (mosi_w !== tx) $display("FAIL %s_mosi: got %h want %h", name, mosi_w, tx); else passed++;
    checks++; if (data !== rx) $display("FAIL %s_data: got %h want %h", name, data, rx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL %s_busy_at_done: got %b want 0", name, busy); else passed++;
    tick();
    checks++; if (csn !== 1'b1 || done !== 1'b0)
      $display("FAIL %s_after_done: csn=%b done=%b want csn=1 done=0", name, csn, done); else passed++;
  endtask

  task automatic test_single;
    do_transfer(8'h3C, 8'hA5, "single");
  endtask

  task automatic test_start_while_busy;
    int dones = 0;
    slv_q.push_back(8'h66);
    tx_data = 8'h0F;
    start   = 1'b1;
    tick();
    for (int k = 1; k <= 250; k++) begin
      start = (k == 10 || k == 40);
      tick();
      if (done) dones++;
    end
    start = 1'b0;
    checks++; if (dones != 1) $display("FAIL busy_start_dones: got %0d want 1", dones); else passed++;
    checks++; if (data !== 8'h66) $display("FAIL busy_start_data: got %h want 66", data); else passed++;
    checks++; if (csn !== 1'b1 || busy !== 1'b0)
      $display("FAIL busy_start_idle: csn=%b busy=%b want csn=1 busy=0", csn, busy); else passed++;
  endtask

  task automatic test_reset_mid_transfer;
    int   rises = 0;
    int   dones = 0;
    logic prev;
    slv_q.push_back(8'h99);
    tx_data = 8'h81;
    start   = 1'b1;
    tick();
    start = 1'b0;
    prev  = sclk;
    for (int k = 0; k < 200 && rises < 3; k++) begin
      tick();
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    checks++; if (rises != 3) $display("FAIL midrst_rises: got %0d want 3", rises); else passed++;
    resetn = 1'b0;
    tick();
    checks++; if (csn !== 1'b1) $display("FAIL midrst_csn: got %b want 1", csn); else passed++;
    checks++; if (sclk !== 1'b0) $display("FAIL midrst_sclk: got %b want 0", sclk); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else passed++;
    checks++; if (data !== 8'h00) $display("FAIL midrst_data: got %h want 00", data); else passed++;
    resetn = 1'b1;
    repeat (100) begin
      tick();
      if (done) dones++;
    end
    checks++; if (dones != 0) $display("FAIL midrst_no_done: got %0d want 0", dones); else passed++;
    slv_q.delete();
    do_transfer(8'hC3, 8'h5A, "after_reset");
  endtask

  task automatic test_back_to_back;
    int              n = 0;
    int              d1 = -1;
    int              d2 = -1;
    int              csn_hi = 0;
    int              extra = 0;
    logic [BITS-1:0] data1 = '0;
    logic [BITS-1:0] data2 = '0;
    slv_q.delete();
    slv_q.push_back(8'h01);
    slv_q.push_back(8'hFE);
    tx_data = 8'h55;
    start   = 1'b1;
    tick();
    for (int k = 1; k <= 400 && n < 2; k++) begin
      tick();
      if (done) begin
        if (n == 0) begin
          d1    = k;
          data1 = data;
        end else begin
          d2    = k;
          data2 = data;
          start = 1'b0;
        end
        n++;
      end
      if (n == 1 && csn) csn_hi++;
    end
    start = 1'b0;
    checks++; if (d1 != LAT) $display("FAIL b2b_first_latency: got %0d want %0d", d1, LAT); else passed++;
    checks++; if (d2 - d1 != LAT + 1) $display("FAIL b2b_gap: got %0d want %0d", d2 - d1, LAT + 1); else passed++;
    checks++; if (data1 !== 8'h01) $display("FAIL b2b_data1: got %h want 01", data1); else passed++;
    checks++; if (data2 !== 8'hFE) $display("FAIL b2b_data2: got %h want fe", data2); else passed++;
    checks++; if (csn_hi != 1) $display("FAIL b2b_csn_high: got %0d cycles want 1", csn_hi); else passed++;
    repeat (100) begin
      tick();
      if (done) extra++;
    end
    checks++; if (extra != 0) $display("FAIL b2b_no_third: got %0d want 0", extra); else passed++;
  endtask

  task automatic test_poll;
    int d0, d1, d2, d3, d4;
    wait_done(d0);
    wait_done(d1);
    checks++; if (d0 < 0 || d1 - d0 != POLL)
      $display("FAIL poll_period: got %0d want %0d", d1 - d0, POLL); else passed++;
    // A user start at d1+100 keeps the master busy across the next poll terminal count.
    repeat (99) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d2);
    wait_done(d3);
    wait_done(d4);
    checks++; if (d2 - d1 != 100 + LAT)
      $display("FAIL poll_user_done: got %0d want %0d", d2 - d1, 100 + LAT); else passed++;
    checks++; if (d2 < 0 || d3 - d2 != LAT + 1)
      $display("FAIL poll_pending: got %0d want %0d", d3 - d2, LAT + 1); else passed++;
    checks++; if (d3 < 0 || d4 - d3 != 2 * POLL - 100 - 2 * LAT - 1)
      $display("FAIL poll_resume: got %0d want %0d", d4 - d3, 2 * POLL - 100 - 2 * LAT - 1); else passed++;
  endtask

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    tx_data = '0;
    test_reset();
`ifdef SPI_BTN_MASTER_POLL_EN
    test_poll();
`else
    test_single();
    test_start_while_busy();
    test_reset_mid_transfer();
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_btn_master.md
Name: spi_btn_master

Overview:
- SPI mode-0 initiator. The FPGA acts as SPI master and reads a C_bits-wide word from a slave. One example slave is a button-state responder that presents its word while CSn is low.
- Full duplex: a latched TX word is shifted out on MOSI while MISO is shifted in.
- Sits between user logic (start/done handshake) and board pins (csn/sclk/mosi/miso, e.g. routed to gp/gn or sd_* lines).

Parameters:
- C_bits, 8, word length in bits (>=1)
- C_clk_div, 4, clk cycles per SCLK half-period (>=1)
- C_csn_setup, 2, clk cycles CSn low before first SCLK rise and after last SCLK fall (>=1)
- C_poll_period, 1000000, auto-poll interval in clk cycles (used only with SPI_BTN_MASTER_POLL_EN)

Ports:
- i_clk  in  1  system clock (clk_25MHz at top level)
- i_resetn  in  1  synchronous reset, active-low
- i_start  in  1  request a transfer; sampled only in IDLE
- i_tx_data  in  C_bits  word to transmit; latched on start acceptance
- o_busy  out  1  high from the cycle after acceptance until the cycle of o_done
- o_done  out  1  one-cycle pulse; o_data valid from this cycle
- o_data  out  C_bits  last received word; held until the next o_done
- o_csn  out  1  SPI chip select, active-low
- o_sclk  out  1  SPI clock, idles low
- o_mosi  out  1  SPI data out, MSB first
- i_miso  in  1  SPI data in, MSB first

Behaviour:
- Reset (i_resetn=0 at a clk edge), applied on the next edge:
  - state=IDLE, o_csn=1, o_sclk=0, o_mosi=0
  - o_busy=0, o_done=0, o_data=0
  - all counters cleared
  - Reset mid-transfer aborts immediately; no o_done is issued.
- IDLE:
  - o_csn=1, o_sclk=0.
  - If i_start=1, latch i_tx_data into the TX shifter and go to SETUP; on that edge o_csn<=0, o_busy<=1, o_mosi<=TX MSB.
- SETUP:
  - Hold o_sclk=0 for C_csn_setup cycles, then go to LOW.
- LOW:
  - o_sclk=0 for C_clk_div cycles.
  - On the edge ending LOW: o_sclk<=1, and i_miso is shifted into the RX shifter LSB (sample at the rising SCLK edge). Go to HIGH.
- HIGH:
  - o_sclk=1 for C_clk_div cycles.
  - On the edge ending HIGH: o_sclk<=0 and the bit counter increments.
  - If bits < C_bits: o_mosi<=next TX bit and go to LOW.
  - Otherwise go to HOLD.
- HOLD:
  - o_csn=0, o_sclk=0 for C_csn_setup cycles.
  - On the final edge: o_csn<=1, o_data<=RX shifter, o_done<=1 for one cycle, o_busy<=0, o_mosi<=0. Go to IDLE.
- Latency: i_start sampled at edge 0 -> o_done high after 1+2*C_csn_setup+2*C_clk_div*C_bits cycles, and o_done lasts one cycle. With defaults this is 69 cycles.
- CSn is high for at least 1 cycle between transfers. If i_start is held high, the next transfer is accepted the cycle after o_done, giving back-to-back transfers.
- i_start while o_busy=1 is ignored; it is neither queued nor counted.
- i_tx_data changes after acceptance have no effect.
- Counters are sized $clog2 of their limit +1; there is no wrap-around inside a transfer.

Optional Feature:
- Macro SPI_BTN_MASTER_POLL_EN.
- Defined:
  - A free-running poll counter counts 0..C_poll_period-1 and is cleared by reset.
  - At terminal count it raises an internal start, ORed with i_start.
  - If the master is busy at terminal count, the poll request stays pending until IDLE, then is accepted. At most one request is pending.
  - Net effect: o_data is refreshed periodically without user action.
- Undefined: the counter logic is absent and transfers occur only via i_start.

Test Plan:
- Reset: hold i_resetn=0 for 3 cycles -> o_csn=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0, o_data=0x00.
- Single transfer, defaults: i_tx_data=0x3C, slave model drives MISO=0xA5 MSB-first on SCLK falls, 1-cycle start pulse ->
  - exactly 8 SCLK rises
  - MOSI sampled at rises = 0x3C
  - o_done 69 cycles after start, o_data=0xA5
  - o_csn high the cycle after o_done
- Start while busy: pulse i_start at cycles 10 and 40 of a transfer -> only one transfer occurs and one o_done.
- Reset mid-transfer: assert i_resetn=0 after the 3rd SCLK rise -> next edge o_csn=1, o_sclk=0, no o_done, o_data=0x00; a following start gives a clean full transfer.
- Back-to-back: i_start held high, MISO words 0x01 then 0xFE ->
  - two o_done pulses 70 cycles apart
  - o_data=0x01 then 0xFE
  - o_csn high for exactly 1 cycle between transfers
- POLL_EN, C_poll_period=200, i_start=0 -> transfers start at poll terminal counts, o_done every 200 cycles; a poll arriving while busy starts right after return to IDLE.
